// File: rtl/imm_alu_sequencer.sv
// imm_alu_sequencer
//   Hardwired control FSM for the immediate-format instructions ldi/addi/andi/ori.
//   Walks fetch (T0-T2) and execute (T3-T5), emitting the datapath strobes for
//   each step. Fetch waits in T1 for RAM data with a bounded timeout. Unknown
//   opcodes and memory timeouts trap into HALT, which only clear_n leaves.
//   Retired instructions are counted modulo 2^CNT_W.
// Ports
//   clock, clear_n           clock and async active-low reset
//   run                      level enable, sampled in IDLE and T5
//   ir_opcode[OPW]           IR opcode field, decoded and latched in T3
//   mem_ready                RAM read data valid (observed in T1)
//   PCout..CSEout            datapath strobes (Moore, zero in IDLE/HALT)
//   ADD, AND, OR             ALU op select, one-hot in T4
//   step[4]                  state encoding for debug
//   done                     one-cycle pulse in T5
//   fault, fault_code[2]     sticky trap flag and cause (01 opcode, 10 timeout)
//   instr_count[CNT_W]       retired instruction counter
module imm_alu_sequencer #(
  parameter int             OPW         = 5,
  parameter logic [OPW-1:0] OP_LDI      = 5'b00001,
  parameter logic [OPW-1:0] OP_ADDI     = 5'b01100,
  parameter logic [OPW-1:0] OP_ANDI     = 5'b01101,
  parameter logic [OPW-1:0] OP_ORI      = 5'b01110,
  parameter int             MEM_TIMEOUT = 15,
  parameter int             CNT_W       = 16
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             run,
  input  logic [OPW-1:0]   ir_opcode,
  input  logic             mem_ready,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zlowin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             MDMuxread,
  output logic             RAMread,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Grb,
  output logic             Rin,
  output logic             Rout,
  output logic             BAout,
  output logic             Yin,
  output logic             CSEout,
  output logic             ADD,
  output logic             AND,
  output logic             OR,
  output logic [3:0]       step,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instr_count
);

  // Encoding is visible on the step port, so values are pinned.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_HALT = 4'd15
  } state_e;

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [1:0]       fcode_q, fcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      op_q    <= '0;
      fcode_q <= FC_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      fcode_q <= fcode_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    op_d      = op_q;
    fcode_d   = fcode_q;
    cnt_d     = cnt_q;
    PCout     = 1'b0;
    MARin     = 1'b0;
    IncPC     = 1'b0;
    Zlowin    = 1'b0;
    Zlowout   = 1'b0;
    PCin      = 1'b0;
    MDMuxread = 1'b0;
    RAMread   = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Gra       = 1'b0;
    Grb       = 1'b0;
    Rin       = 1'b0;
    Rout      = 1'b0;
    BAout     = 1'b0;
    Yin       = 1'b0;
    CSEout    = 1'b0;
    ADD       = 1'b0;
    AND       = 1'b0;
    OR        = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: if (run) state_d = S_T0;

      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zlowin  = 1'b1;
        state_d = S_T1;
      end

      // Strobes are held for every wait cycle; rewriting PC with the same
      // Z value on each of them is harmless.
      S_T1: begin
        Zlowout   = 1'b1;
        PCin      = 1'b1;
        MDMuxread = 1'b1;
        RAMread   = 1'b1;
        MDRin     = 1'b1;
        if (mem_ready) begin
          // Data arriving on the last allowed cycle still wins over timeout.
          state_d = S_T2;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          fcode_d = FC_TIMEOUT;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + 1'b1;
        end
      end

      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end

      // IR was loaded at the end of T2, so ir_opcode is a registered value
      // here; it is latched for the T4 ALU select.
      S_T3: begin
        op_d = ir_opcode;
        if (ir_opcode == OP_LDI) begin
          // BAout on R0 reads zero, so ldi computes 0 + C.
          Grb     = 1'b1;
          BAout   = 1'b1;
          Yin     = 1'b1;
          state_d = S_T4;
        end else if (ir_opcode == OP_ADDI || ir_opcode == OP_ANDI ||
                     ir_opcode == OP_ORI) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = S_T4;
        end else begin
          state_d = S_HALT;
          fcode_d = FC_ILLEGAL;
        end
      end

      S_T4: begin
        CSEout  = 1'b1;
        Zlowin  = 1'b1;
        ADD     = (op_q == OP_LDI) || (op_q == OP_ADDI);
        AND     = (op_q == OP_ANDI);
        OR      = (op_q == OP_ORI);
        state_d = S_T5;
      end

      S_T5: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        done    = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = run ? S_T0 : S_IDLE;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_IDLE;
    endcase
  end

  assign step        = state_q;
  assign fault       = (state_q == S_HALT);
  assign fault_code  = fcode_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// Bench for imm_alu_sequencer: a small behavioural datapath (PC, MAR, MDR, IR,
// Y, Z, register file, RAM) is driven by the sequencer strobes so results land
// in registers and can be compared with hand-computed values.
module tb_imm_alu_sequencer;
  localparam int CW = 4;
  localparam logic [4:0] LDI  = 5'b00001;
  localparam logic [4:0] ADDI = 5'b01100;
  localparam logic [4:0] ANDI = 5'b01101;
  localparam logic [4:0] ORI  = 5'b01110;

  logic clock = 1'b0, clear_n = 1'b0, run = 1'b0, mem_ready = 1'b1;
  logic [4:0] ir_opcode;
  logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDMuxread, RAMread, MDRin;
  logic MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, CSEout, ADD, AND, OR;
  logic [3:0] step;
  logic done, fault;
  logic [1:0] fault_code;
  logic [CW-1:0] instr_count;
  logic [20:0] sv;

  int n_pass = 0, n_tot = 0;

  always #5 clock = ~clock;

  imm_alu_sequencer #(.CNT_W(CW)) dut (
    .clock(clock), .clear_n(clear_n), .run(run), .ir_opcode(ir_opcode),
    .mem_ready(mem_ready), .PCout(PCout), .MARin(MARin), .IncPC(IncPC),
    .Zlowin(Zlowin), .Zlowout(Zlowout), .PCin(PCin), .MDMuxread(MDMuxread),
    .RAMread(RAMread), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Gra(Gra),
    .Grb(Grb), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Yin(Yin), .CSEout(CSEout),
    .ADD(ADD), .AND(AND), .OR(OR), .step(step), .done(done), .fault(fault),
    .fault_code(fault_code), .instr_count(instr_count)
  );

  assign sv = {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, MDMuxread, RAMread,
               MDRin, MDRout, IRin, Gra, Grb, Rin, Rout, BAout, Yin, CSEout,
               ADD, AND, OR};

  // ---------------- behavioural datapath ----------------
  logic [31:0] pc_m = 32'd0;
  logic [31:0] mar_m, mdr_m, ir_m, y_m, z_m, bus;
  logic [31:0] rf [16];
  logic [31:0] ram [256];
  logic [3:0]  sel;

  assign ir_opcode = ir_m[31:27];

  always_comb begin
    sel = Gra ? ir_m[26:23] : (Grb ? ir_m[22:19] : 4'd0);
    bus = 32'd0;
    if (PCout)        bus = pc_m;
    else if (Zlowout) bus = z_m;
    else if (MDRout)  bus = mdr_m;
    else if (Rout)    bus = rf[sel];
    else if (BAout)   bus = (sel == 4'd0) ? 32'd0 : rf[sel];
    else if (CSEout)  bus = {{13{ir_m[18]}}, ir_m[18:0]};
  end

  always @(posedge clock) begin
    if (MARin) mar_m <= bus;
    if (PCin)  pc_m  <= bus;
    if (Zlowin) z_m  <= IncPC ? bus + 32'd1 : ADD ? y_m + bus :
                        AND ? (y_m & bus) : OR ? (y_m | bus) : bus;
    if (MDRin && MDMuxread && RAMread && mem_ready) mdr_m <= ram[mar_m[7:0]];
    if (IRin) ir_m <= bus;
    if (Yin)  y_m  <= bus;
    if (Rin)  rf[sel] <= bus;
  end

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [3:0] ra,
                                      input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  // ---------------- run bookkeeping ----------------
  logic [63:0] tr;
  logic [2:0]  alu_q [$];
  logic [20:0] st3;
  int ndone, nt1;

  // Issues n instructions back to back (run dropped at the n-th T0) and keeps
  // mem_ready low for the first lowcyc cycles of each T1. Stops at IDLE/HALT.
  task automatic run_n(input int n, input int lowcyc, output bit ok);
    int t0s, g, cur;
    t0s = 0; g = 0; cur = 0; ok = 1'b0;
    tr = '0; alu_q.delete(); ndone = 0; nt1 = 0; st3 = '1;
    mem_ready = (lowcyc == 0);
    run = 1'b1;
    while (g < 600 && !ok) begin
      @(negedge clock); g++;
      tr = {tr[59:0], step};
      case (step)
        4'd1: begin t0s++; cur = 0; mem_ready = (lowcyc == 0); if (t0s == n) run = 1'b0; end
        4'd2: begin cur++; nt1++; mem_ready = (cur > lowcyc); end
        4'd4: st3 = sv;
        4'd5: alu_q.push_back({ADD, AND, OR});
        4'd0, 4'd15: if (t0s > 0) ok = 1'b1;
        default: ;
      endcase
      if (done) ndone++;
    end
    mem_ready = 1'b1;
    run = 1'b0;
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    n_tot++; if (step !== 4'd0) $display("FAIL reset_step got %0h want 0", step); else n_pass++;
    n_tot++; if (sv !== 21'd0) $display("FAIL reset_strobes got %h want 0", sv); else n_pass++;
    n_tot++; if ({done, fault, fault_code} !== 4'd0) $display("FAIL reset_flags got %b want 0000", {done, fault, fault_code}); else n_pass++;
    n_tot++; if (instr_count !== 4'd0) $display("FAIL reset_count got %0d want 0", instr_count); else n_pass++;
    @(negedge clock); @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock); @(negedge clock);
    n_tot++; if (step !== 4'd0) $display("FAIL idle_hold got %0h want 0", step); else n_pass++;
  endtask

  task automatic test_sequence();
    bit ok;
    ram[pc_m[7:0]]        = ins(LDI, 4'd4, 4'd0, 19'h50);
    ram[pc_m[7:0] + 8'd1] = ins(ANDI, 4'd3, 4'd4, 19'h53);
    run_n(2, 0, ok);
    n_tot++; if (!ok) $display("FAIL seq_timeout got no return to IDLE"); else n_pass++;
    n_tot++; if (tr[51:0] !== 52'h1234561234560) $display("FAIL seq_trace got %h want 1234561234560", tr[51:0]); else n_pass++;
    n_tot++; if (ndone != 2) $display("FAIL seq_done got %0d want 2", ndone); else n_pass++;
    n_tot++; if (rf[4] !== 32'h50) $display("FAIL seq_r4 got %h want 50", rf[4]); else n_pass++;
    n_tot++; if (rf[3] !== 32'h50) $display("FAIL seq_r3 got %h want 50", rf[3]); else n_pass++;
    n_tot++; if (instr_count !== 4'd2) $display("FAIL seq_count got %0d want 2", instr_count); else n_pass++;
    n_tot++; if (alu_q.size() != 2 || alu_q[0] !== 3'b100 || alu_q[1] !== 3'b010) $display("FAIL seq_alu got %0d entries want 100,010", alu_q.size()); else n_pass++;
    n_tot++; if (st3 !== 21'h150) $display("FAIL seq_andi_t3 got %h want 150", st3); else n_pass++;
  endtask

  task automatic test_alu_ops();
    bit ok;
    ram[pc_m[7:0]]        = ins(ORI, 4'd5, 4'd4, 19'h0F);
    ram[pc_m[7:0] + 8'd1] = ins(ADDI, 4'd6, 4'd4, 19'h7FFFF);
    run_n(2, 0, ok);
    n_tot++; if (!ok) $display("FAIL alu_timeout got no return to IDLE"); else n_pass++;
    n_tot++; if (rf[5] !== 32'h5F) $display("FAIL ori_r5 got %h want 5f", rf[5]); else n_pass++;
    n_tot++; if (rf[6] !== 32'h4F) $display("FAIL addi_r6 got %h want 4f", rf[6]); else n_pass++;
    n_tot++; if (alu_q.size() != 2 || alu_q[0] !== 3'b001 || alu_q[1] !== 3'b100) $display("FAIL alu_onehot got %0d entries want 001,100", alu_q.size()); else n_pass++;
    n_tot++; if (instr_count !== 4'd4) $display("FAIL alu_count got %0d want 4", instr_count); else n_pass++;
  endtask

  task automatic test_mem_wait();
    bit ok;
    logic [31:0] w;
    w = ins(LDI, 4'd8, 4'd0, 19'h123);
    ram[pc_m[7:0]] = w;
    run_n(1, 3, ok);
    n_tot++; if (nt1 != 4) $display("FAIL wait_t1_len got %0d want 4", nt1); else n_pass++;
    n_tot++; if (tr[39:0] !== 40'h1222234560) $display("FAIL wait_trace got %h want 1222234560", tr[39:0]); else n_pass++;
    n_tot++; if (ir_m !== w) $display("FAIL wait_ir got %h want %h", ir_m, w); else n_pass++;
    n_tot++; if (rf[8] !== 32'h123 || fault !== 1'b0) $display("FAIL wait_result got r8=%h fault=%b want 123/0", rf[8], fault); else n_pass++;
    // mem_ready arriving on the 15th wait cycle must still beat the timeout
    ram[pc_m[7:0]] = ins(ORI, 4'd9, 4'd8, 19'h0F0);
    run_n(1, 14, ok);
    n_tot++; if (nt1 != 15) $display("FAIL edge_t1_len got %0d want 15", nt1); else n_pass++;
    n_tot++; if (step !== 4'd0 || fault !== 1'b0) $display("FAIL edge_state got step=%0h fault=%b want 0/0", step, fault); else n_pass++;
    n_tot++; if (rf[9] !== 32'h1F3) $display("FAIL edge_r9 got %h want 1f3", rf[9]); else n_pass++;
    n_tot++; if (instr_count !== 4'd6) $display("FAIL edge_count got %0d want 6", instr_count); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok, bad;
    bad = 1'b0;
    ram[pc_m[7:0]] = ins(LDI, 4'd10, 4'd0, 19'h55);
    run_n(1, 1000, ok);
    n_tot++; if (nt1 != 15) $display("FAIL tmo_t1_len got %0d want 15", nt1); else n_pass++;
    n_tot++; if (step !== 4'd15 || fault !== 1'b1) $display("FAIL tmo_halt got step=%0h fault=%b want f/1", step, fault); else n_pass++;
    n_tot++; if (fault_code !== 2'b10) $display("FAIL tmo_code got %b want 10", fault_code); else n_pass++;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (step !== 4'd15 || sv !== 21'd0 || done !== 1'b0) bad = 1'b1;
    end
    run = 1'b0;
    n_tot++; if (bad) $display("FAIL tmo_quiet got activity in HALT want none"); else n_pass++;
    n_tot++; if (instr_count !== 4'd6) $display("FAIL tmo_count got %0d want 6", instr_count); else n_pass++;
  endtask

  task automatic test_illegal();
    bit ok, bad;
    bad = 1'b0;
    do_reset();
    ram[pc_m[7:0]] = ins(5'b11111, 4'd11, 4'd4, 19'h1);
    run_n(1, 0, ok);
    n_tot++; if (tr[19:0] !== 20'h1234F) $display("FAIL ill_trace got %h want 1234f", tr[19:0]); else n_pass++;
    n_tot++; if (st3 !== 21'd0) $display("FAIL ill_t3_strobes got %h want 0", st3); else n_pass++;
    n_tot++; if (fault !== 1'b1 || fault_code !== 2'b01) $display("FAIL ill_code got %b/%b want 1/01", fault, fault_code); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (Rin !== 1'b0 || Zlowin !== 1'b0 || step !== 4'd15) bad = 1'b1;
    end
    n_tot++; if (bad) $display("FAIL ill_no_write got Rin/Zlowin or exit want none"); else n_pass++;
    n_tot++; if (instr_count !== 4'd0) $display("FAIL ill_count got %0d want 0", instr_count); else n_pass++;
  endtask

  task automatic test_abort();
    bit ok;
    int g;
    do_reset();
    ram[pc_m[7:0]]        = ins(LDI, 4'd12, 4'd0, 19'h3C);
    ram[pc_m[7:0] + 8'd1] = ins(ANDI, 4'd3, 4'd4, 19'h0F);
    run_n(1, 0, ok);
    n_tot++; if (instr_count !== 4'd1) $display("FAIL abort_pre_count got %0d want 1", instr_count); else n_pass++;
    run = 1'b1; g = 0;
    while (step !== 4'd5 && g < 30) begin @(negedge clock); g++; end
    n_tot++; if (step !== 4'd5) $display("FAIL abort_reach_t4 got %0h want 5", step); else n_pass++;
    clear_n = 1'b0;
    run = 1'b0;
    #1;
    n_tot++; if (step !== 4'd0 || sv !== 21'd0) $display("FAIL abort_async got step=%0h strobes=%h want 0/0", step, sv); else n_pass++;
    n_tot++; if (done !== 1'b0 || fault !== 1'b0 || instr_count !== 4'd0) $display("FAIL abort_flags got done=%b fault=%b cnt=%0d want 0/0/0", done, fault, instr_count); else n_pass++;
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    n_tot++; if (rf[3] !== 32'h50) $display("FAIL abort_r3 got %h want 50", rf[3]); else n_pass++;
    ram[pc_m[7:0]] = ins(LDI, 4'd13, 4'd0, 19'h66);
    run_n(1, 0, ok);
    n_tot++; if (tr[27:0] !== 28'h1234560) $display("FAIL restart_trace got %h want 1234560", tr[27:0]); else n_pass++;
    n_tot++; if (rf[13] !== 32'h66 || instr_count !== 4'd1) $display("FAIL restart_result got r13=%h cnt=%0d want 66/1", rf[13], instr_count); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    for (int k = 0; k < 15; k++)
      ram[pc_m[7:0] + 8'(k)] = ins(LDI, 4'd7, 4'd0, 19'(k + 1));
    run_n(14, 0, ok);
    n_tot++; if (ndone != 14) $display("FAIL wrap_done got %0d want 14", ndone); else n_pass++;
    n_tot++; if (instr_count !== 4'hF) $display("FAIL wrap_full got %0d want 15", instr_count); else n_pass++;
    run_n(1, 0, ok);
    n_tot++; if (ndone != 1) $display("FAIL wrap_last_done got %0d want 1", ndone); else n_pass++;
    n_tot++; if (instr_count !== 4'd0) $display("FAIL wrap_zero got %0d want 0", instr_count); else n_pass++;
    n_tot++; if (rf[7] !== 32'hF) $display("FAIL wrap_r7 got %h want f", rf[7]); else n_pass++;
    n_tot++; if (st3 !== 21'h130) $display("FAIL ldi_t3 got %h want 130", st3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_alu_ops();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_abort();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end

endmodule
